// File: rtl/control_faza_masini.sv
// Intersection phase sequencer: car lights plus counter/enable
// for the pedestrian light controller.
module control_faza_masini #(
    parameter int MIN_GREEN    = 20,
    parameter int YELLOW_TIME  = 4,
    parameter int ALL_RED_TIME = 2,
    parameter int PED_TIME     = 20
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       w_p_i,
    output logic       Rosu_masini_o,
    output logic       Galben_masini_o,
    output logic       Verde_masini_o,
    output logic       enable_pietoni_o,
    output logic [4:0] counter_o,
    output logic       cerere_o
);

    typedef enum logic [1:0] {
        S_GREEN,
        S_YELLOW,
        S_ALL_RED,
        S_PED
    } state_t;

    localparam logic [7:0] GREEN_LAST  = 8'(MIN_GREEN - 1);
    localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_TIME - 1);
    localparam logic [7:0] RED_LAST    = 8'(ALL_RED_TIME - 1);
    localparam logic [7:0] PED_LAST    = 8'(PED_TIME - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_timer;
    logic [7:0] w_timer_nxt;
    logic       r_flag;
    logic       w_flag_nxt;
    logic       r_en;
    logic       w_en_nxt;
    logic [4:0] r_cnt;
    logic [4:0] w_cnt_nxt;
    logic       w_change;

    // Next state, timer, request flag and pedestrian-side outputs
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_GREEN: begin
                if (r_timer == GREEN_LAST && r_flag)
                    w_state_nxt = S_YELLOW;
            end
            S_YELLOW: begin
                if (r_timer == YELLOW_LAST)
                    w_state_nxt = S_ALL_RED;
            end
            S_ALL_RED: begin
                if (r_timer == RED_LAST)
                    w_state_nxt = S_PED;
            end
            S_PED: begin
                if (r_timer == PED_LAST)
                    w_state_nxt = S_GREEN;
            end
        endcase

        w_change = (w_state_nxt != r_state);

        // Green timer parks at its last value so a late press is served
        // on the very next evaluation.
        if (w_change)
            w_timer_nxt = 8'd0;
        else if (r_state == S_GREEN && r_timer == GREEN_LAST)
            w_timer_nxt = r_timer;
        else
            w_timer_nxt = r_timer + 8'd1;

        // Entering PED serves the request, so clear beats a same-cycle set.
        w_flag_nxt = r_flag;
        if (r_state != S_PED && w_p_i)
            w_flag_nxt = 1'b1;
        if (w_change && w_state_nxt == S_PED)
            w_flag_nxt = 1'b0;

        w_en_nxt  = (w_state_nxt == S_PED);
        w_cnt_nxt = w_en_nxt ? w_timer_nxt[4:0] : 5'd0;
    end

    // State, timer, flag and pedestrian outputs register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_GREEN;
            r_timer <= 8'd0;
            r_flag  <= 1'b0;
            r_en    <= 1'b0;
            r_cnt   <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_flag  <= w_flag_nxt;
            r_en    <= w_en_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Car light decode: exactly one lamp per state
    always_comb begin
        Verde_masini_o  = 1'b0;
        Galben_masini_o = 1'b0;
        Rosu_masini_o   = 1'b0;
        unique case (r_state)
            S_GREEN:   Verde_masini_o  = 1'b1;
            S_YELLOW:  Galben_masini_o = 1'b1;
            S_ALL_RED: Rosu_masini_o   = 1'b1;
            S_PED:     Rosu_masini_o   = 1'b1;
        endcase
    end

    assign enable_pietoni_o = r_en;
    assign counter_o        = r_cnt;
    assign cerere_o         = r_flag;

endmodule

// File: tb/tb_control_faza_masini.sv
// Bench for control_faza_masini: segment table drives per-cycle
// expectations into a scoreboard that is checked after each edge.
module tb_control_faza_masini;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wp  = 1'b0;
    logic       rosu;
    logic       galben;
    logic       verde;
    logic       en;
    logic [4:0] cnt;
    logic       cer;

    always #5 clk = ~clk;

    control_faza_masini dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .w_p_i            (wp),
        .Rosu_masini_o    (rosu),
        .Galben_masini_o  (galben),
        .Verde_masini_o   (verde),
        .enable_pietoni_o (en),
        .counter_o        (cnt),
        .cerere_o         (cer)
    );

    typedef struct {
        logic       rst;
        logic       wp;
        int         n;
        logic [2:0] lt;
        logic       en;
        int         c0;
        logic       cer;
    } seg_t;

    typedef struct {
        logic [2:0] lt;
        logic       en;
        logic [4:0] cnt;
        logic       cer;
    } exp_t;

    seg_t segs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(input logic r, input logic w,
                                input int n, input logic [2:0] lt,
                                input logic e, input int c0,
                                input logic c);
        seg_t s;
        s.rst = r;
        s.wp  = w;
        s.n   = n;
        s.lt  = lt;
        s.en  = e;
        s.c0  = c0;
        s.cer = c;
        segs.push_back(s);
    endfunction

    task automatic chk(input string name, input int cyc,
                       input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s @cycle %0d: actual %0h required %0h",
                     name, cyc, act, req);
        end
    endtask

    initial begin
        exp_t e;
        exp_t got;
        int   cyc = 0;

        // reset
        add(1, 0,   2, G, 0, 0, 0);
        // idle green for 200 cycles
        add(0, 0, 200, G, 0, 0, 0);
        // press on saturated timer: flag next, yellow one edge later
        add(0, 1,   1, G, 0, 0, 1);
        add(0, 0,   4, Y, 0, 0, 1);
        add(0, 0,   2, R, 0, 0, 1);
        add(0, 0,  20, R, 1, 0, 0);
        // one-cycle press at green cycle 5
        add(0, 0,   6, G, 0, 0, 0);
        add(0, 1,   1, G, 0, 0, 1);
        add(0, 0,  13, G, 0, 0, 1);
        add(0, 0,   4, Y, 0, 0, 1);
        add(0, 0,   2, R, 0, 0, 1);
        // press on the edge into PED, then during PED and its last edge
        add(0, 1,   1, R, 1, 0, 0);
        add(0, 0,   4, R, 1, 1, 0);
        add(0, 1,   5, R, 1, 5, 0);
        add(0, 0,   5, R, 1, 10, 0);
        add(0, 1,   5, R, 1, 15, 0);
        add(0, 1,   1, G, 0, 0, 0);
        add(0, 0,  60, G, 0, 0, 0);
        // press during yellow is served by a single PED
        add(0, 1,   1, G, 0, 0, 1);
        add(0, 0,   1, Y, 0, 0, 1);
        add(0, 1,   1, Y, 0, 0, 1);
        add(0, 0,   2, Y, 0, 0, 1);
        add(0, 0,   2, R, 0, 0, 1);
        add(0, 0,  20, R, 1, 0, 0);
        add(0, 0,  30, G, 0, 0, 0);
        // button held: 46-cycle period
        add(0, 1,   1, G, 0, 0, 1);
        for (int k = 0; k < 2; k++) begin
            add(0, 1,  4, Y, 0, 0, 1);
            add(0, 1,  2, R, 0, 0, 1);
            add(0, 1, 20, R, 1, 0, 0);
            add(0, 1,  1, G, 0, 0, 0);
            add(0, 1, 19, G, 0, 0, 1);
        end
        // reset pulse at counter 9 of PED
        add(0, 1,   4, Y, 0, 0, 1);
        add(0, 1,   2, R, 0, 0, 1);
        add(0, 1,  10, R, 1, 0, 0);
        add(1, 1,   1, G, 0, 0, 0);
        add(0, 0,  10, G, 0, 0, 0);

        foreach (segs[s]) begin
            for (int i = 0; i < segs[s].n; i++) begin
                @(negedge clk);
                rst   = segs[s].rst;
                wp    = segs[s].wp;
                e.lt  = segs[s].lt;
                e.en  = segs[s].en;
                e.cnt = segs[s].en ? 5'(segs[s].c0 + i) : 5'd0;
                e.cer = segs[s].cer;
                sb.push_back(e);
                @(posedge clk);
                #1;
                cyc++;
                got = sb.pop_front();
                chk("lights", cyc, {5'd0, rosu, galben, verde},
                    {5'd0, got.lt});
                chk("onehot", cyc,
                    8'(int'(rosu) + int'(galben) + int'(verde)), 8'd1);
                chk("enable", cyc, {7'd0, en}, {7'd0, got.en});
                chk("counter", cyc, {3'd0, cnt}, {3'd0, got.cnt});
                chk("cerere", cyc, {7'd0, cer}, {7'd0, got.cer});
            end
        end
        chk("sb_empty", cyc, 8'(sb.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
